// File: rtl/module_uart_rx_periph.sv
// module_uart_rx_periph: memory-mapped 8N1 UART receiver with a read-only data register,
// a W1C status register (valid/overrun/frame_err/busy) and a level interrupt on valid.
module module_uart_rx_periph #(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rx_i,
   input  logic        we_proc_i,
   input  logic [31:0] addr_proc_i,
   input  logic [31:0] do_proc_i,
   output logic [31:0] di_proc_o,
   output logic        rx_irq_o
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
   logic [1:0]    r_sync;
   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift, r_data;
   logic          r_valid, r_ovr, r_ferr;
   logic          w_rxs, w_full, w_tick, w_done, w_busy, w_unused;
   logic [2:0]    w_clr;
   assign w_rxs  = r_sync[1];
   assign w_full = r_cnt == FULL;
   assign w_tick = r_state == START ? r_cnt == HALF : w_full;
   assign w_done = r_state == STOP && w_full;
   assign w_busy = r_state != IDLE;
   assign w_clr  = (we_proc_i && !addr_proc_i[10]) ? do_proc_i[2:0] : 3'b000;
   assign w_unused = ^{addr_proc_i[31:11], addr_proc_i[9:0], do_proc_i[31:3]};
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync    <= 2'b11;
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ovr     <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], rx_i};
         r_cnt  <= (r_state == IDLE || w_tick) ? '0 : r_cnt + 1'b1;
         case (r_state)
            IDLE:  if (!w_rxs) r_state <= START;
            START: if (w_tick) begin
               r_state   <= w_rxs ? IDLE : DATA;
               r_bit_idx <= '0;
            end
            DATA:  if (w_tick) begin
               r_shift   <= {w_rxs, r_shift[7:1]};
               r_bit_idx <= r_bit_idx + 1'b1;
               if (r_bit_idx == 3'd7) r_state <= STOP;
            end
            default: if (w_tick) r_state <= IDLE;
         endcase
         if (w_done) r_data <= r_shift;
         // A completing byte dominates a same-cycle clear of valid; overrun only if valid survives the clear.
         r_valid <= w_done | (r_valid & ~w_clr[0]);
         r_ovr   <= (w_done & r_valid & ~w_clr[0]) | (r_ovr & ~w_clr[1]);
         r_ferr  <= (w_done & ~w_rxs) | (r_ferr & ~w_clr[2]);
      end
   end
   assign di_proc_o = addr_proc_i[10] ? {24'b0, r_data} : {28'b0, w_busy, r_ferr, r_ovr, r_valid};
   assign rx_irq_o  = r_valid;
endmodule
